// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
// Bundle of the signals exchanged between the decode/issue side and the
// execute stage. The master drives instruction fields and pipe control. The
// slave (the execute stage) returns the stall request and the E/M register
// contents.
//   en, flush           : advance enable / bubble insert
//   alu_src, alu_ctrl   : operand-B select, ALU operation
//   src_a, rd2, imm     : operands and sign-extended byte offset
//   pc_e, write_data_e,
//   write_reg_e         : instruction context carried into M
//   alu_busy            : multiply in progress (combinational)
//   *_m                 : registered E/M fields
// -----------------------------------------------------------------------------
interface execute_stage_if;
  logic        en;
  logic        flush;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [31:0] pc_e;
  logic [31:0] write_data_e;
  logic [4:0]  write_reg_e;
  logic        alu_busy;
  logic [31:0] alu_out_m;
  logic        zero_m;
  logic [31:0] target_m;
  logic [31:0] write_data_m;
  logic [4:0]  write_reg_m;
  logic [31:0] pc_m;

  modport master (
    output en, flush, alu_src, alu_ctrl, src_a, rd2, imm, pc_e,
           write_data_e, write_reg_e,
    input  alu_busy, alu_out_m, zero_m, target_m, write_data_m,
           write_reg_m, pc_m
  );

  modport slave (
    input  en, flush, alu_src, alu_ctrl, src_a, rd2, imm, pc_e,
           write_data_e, write_reg_e,
    output alu_busy, alu_out_m, zero_m, target_m, write_data_m,
           write_reg_m, pc_m
  );
endinterface

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Execute stage of the pipeline. It selects ALU operand B and evaluates the
// ALU operation. MUL is multi-cycle and stalls the pipe through alu_busy. The
// stage also forms the PC-relative target pc_e + imm, and the results are
// captured in the E/M register under stall (en / alu_busy) and flush control.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears the E/M register and the MUL counter
//   bus   : execute_stage_if.slave (instruction fields in, E/M fields out)
// Parameter MUL_LAT (>=2): number of cycles a MUL occupies the stage.
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int MUL_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [2:0] OP_MUL = 3'b111;

  function automatic logic [31:0] alu_eval(input logic [2:0]  ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (ctrl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = {31'd0, (sa < sb)};
      3'b110:  r = a << b[4:0];
      default: r = a * b;  // low word only; operands are held stable while busy
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [31:0]      alu_out_q,      alu_out_d;
  logic             zero_q,         zero_d;
  logic [31:0]      target_q,       target_d;
  logic [31:0]      write_data_q,   write_data_d;
  logic [4:0]       write_reg_q,    write_reg_d;
  logic [31:0]      pc_q,           pc_d;

  logic [31:0] b_opnd;
  logic [31:0] result;
  logic        busy;
  logic        upd;

  always_comb begin
    b_opnd       = bus.alu_src ? bus.imm : bus.rd2;
    result       = alu_eval(bus.alu_ctrl, bus.src_a, b_opnd);
    busy         = (bus.alu_ctrl == OP_MUL) && (cnt_q != CNT_LAST);
    upd          = bus.en && !busy;

    // The counter runs only while busy. It parks at CNT_LAST until the E/M
    // register actually captures, so a stalled MUL result is not lost.
    cnt_d        = cnt_q;
    if (busy) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (upd && (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end

    alu_out_d    = alu_out_q;
    zero_d       = zero_q;
    target_d     = target_q;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    pc_d         = pc_q;
    if (upd) begin
      if (bus.flush) begin
        // Bubble: write_reg 0 means no register write in later stages.
        alu_out_d    = '0;
        zero_d       = 1'b0;
        target_d     = '0;
        write_data_d = '0;
        write_reg_d  = '0;
        pc_d         = '0;
      end else begin
        alu_out_d    = result;
        zero_d       = (result == 32'd0);
        target_d     = bus.pc_e + bus.imm;
        write_data_d = bus.write_data_e;
        write_reg_d  = bus.write_reg_e;
        pc_d         = bus.pc_e;
      end
    end
  end

  // E/M register boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      alu_out_q    <= '0;
      zero_q       <= 1'b0;
      target_q     <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      pc_q         <= '0;
    end else begin
      cnt_q        <= cnt_d;
      alu_out_q    <= alu_out_d;
      zero_q       <= zero_d;
      target_q     <= target_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      pc_q         <= pc_d;
    end
  end

  assign bus.alu_busy     = busy;
  assign bus.alu_out_m    = alu_out_q;
  assign bus.zero_m       = zero_q;
  assign bus.target_m     = target_q;
  assign bus.write_data_m = write_data_q;
  assign bus.write_reg_m  = write_reg_q;
  assign bus.pc_m         = pc_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Scoreboard bench for execute_stage (MUL_LAT = 5). Expected E/M contents are
// pushed when an instruction is driven and popped when the register captures.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  localparam int MUL_LAT = 5;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] tgt;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] pc;
  } em_t;

  logic clk;
  logic reset;
  execute_stage_if bus();

  execute_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  tests;
  int  fails;
  em_t sb_q[$];
  em_t last;
  em_t exp_v;
  em_t obs_v;

  function automatic em_t observe();
    em_t o;
    o.alu  = bus.alu_out_m;
    o.zero = bus.zero_m;
    o.tgt  = bus.target_m;
    o.wd   = bus.write_data_m;
    o.wr   = bus.write_reg_m;
    o.pc   = bus.pc_m;
    return o;
  endfunction

  function automatic em_t model(input logic [2:0] ctrl, input logic src,
                                input logic [31:0] a, input logic [31:0] r2,
                                input logic [31:0] im, input logic [31:0] pc,
                                input logic [31:0] wd, input logic [4:0] wr);
    em_t         e;
    logic [31:0] b;
    logic [31:0] r;
    b = src ? im : r2;
    case (ctrl)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    r = a << b[4:0];
      default: r = a * b;
    endcase
    e.alu  = r;
    e.zero = (r == 32'd0);
    e.tgt  = pc + im;
    e.wd   = wd;
    e.wr   = wr;
    e.pc   = pc;
    return e;
  endfunction

  task automatic drive(input logic [2:0] ctrl, input logic src,
                       input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] pc,
                       input logic [31:0] wd, input logic [4:0] wr);
    bus.alu_ctrl     = ctrl;
    bus.alu_src      = src;
    bus.src_a        = a;
    bus.rd2          = r2;
    bus.imm          = im;
    bus.pc_e         = pc;
    bus.write_data_e = wd;
    bus.write_reg_e  = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.en = 1'b1;
    bus.flush = 1'b0;
    drive(3'd0, 1'b0, 32'd11, 32'd22, 32'd4, 32'h80, 32'hABCD, 5'd4);
    tick();
    tick();
    obs_v = observe();
    tests++;
    if (obs_v !== em_t'(0)) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs_v, em_t'(0));
    end
    tests++;
    if (bus.alu_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_add: got %b expected 0", bus.alu_busy);
    end
    bus.alu_ctrl = 3'd7;
    #1;
    tests++;
    if (bus.alu_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy_mul: got %b expected 1", bus.alu_busy);
    end
    bus.alu_ctrl = 3'd0;
    reset = 1'b1;
    last = '0;
  endtask

  task automatic test_add();
    drive(3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 32'hDEAD, 5'd3);
    sb_q.push_back(model(3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 32'hDEAD, 5'd3));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v || obs_v.alu !== 32'd12) begin
      fails++;
      $display("FAIL add: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
  endtask

  task automatic test_sub_branch();
    drive(3'd1, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 32'h55, 5'd7);
    sb_q.push_back(model(3'd1, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 32'h55, 5'd7));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v || obs_v.tgt !== 32'h120 || obs_v.zero !== 1'b1) begin
      fails++;
      $display("FAIL sub_branch: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
  endtask

  task automatic test_imm();
    drive(3'd5, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h104, 32'h1, 5'd8);
    sb_q.push_back(model(3'd5, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h104, 32'h1, 5'd8));
    drive(3'd5, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h104, 32'h1, 5'd8);
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v || obs_v.alu !== 32'd1) begin
      fails++;
      $display("FAIL imm_slt: got %h expected %h", obs_v, exp_v);
    end
    drive(3'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h108, 32'h2, 5'd9);
    sb_q.push_back(model(3'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h108, 32'h2, 5'd9));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v || obs_v.zero !== 1'b1) begin
      fails++;
      $display("FAIL imm_add_wrap: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c;
    logic        s;
    logic [31:0] a, r2, im, pc, wd;
    logic [4:0]  wr;
    for (int i = 0; i < 16; i++) begin
      c  = 3'($urandom_range(0, 6));
      s  = 1'($urandom_range(0, 1));
      a  = $urandom;
      r2 = $urandom;
      im = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      wr = 5'($urandom_range(0, 31));
      if (i % 4 == 0) begin
        c = 3'd1;
        s = 1'b0;
        r2 = a;
      end
      drive(c, s, a, r2, im, pc, wd, wr);
      sb_q.push_back(model(c, s, a, r2, im, pc, wd, wr));
      #1;
      tests++;
      if (bus.alu_busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b_busy[%0d]: got %b expected 0", i, bus.alu_busy);
      end
      tick();
      exp_v = sb_q.pop_front();
      obs_v = observe();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL b2b[%0d] op%0d: got %h expected %h", i, c, obs_v, exp_v);
      end
      last = exp_v;
    end
  endtask

  // Runs one MUL with en held high; busy and hold checked every cycle.
  task automatic run_mul(input string tag, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] pc,
                         input logic [4:0] wr);
    drive(3'd7, 1'b0, a, r2, 32'h10, pc, a ^ r2, wr);
    sb_q.push_back(model(3'd7, 1'b0, a, r2, 32'h10, pc, a ^ r2, wr));
    for (int c = 0; c < MUL_LAT; c++) begin
      #1;
      tests++;
      if (bus.alu_busy !== (c < MUL_LAT - 1)) begin
        fails++;
        $display("FAIL %s_busy[c%0d]: got %b expected %b", tag, c, bus.alu_busy,
                 (c < MUL_LAT - 1));
      end
      tick();
      if (c < MUL_LAT - 1) begin
        obs_v = observe();
        tests++;
        if (obs_v !== last) begin
          fails++;
          $display("FAIL %s_hold[c%0d]: got %h expected %h", tag, c, obs_v, last);
        end
      end
    end
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL %s_result: got %h expected %h", tag, obs_v, exp_v);
    end
    last = exp_v;
  endtask

  task automatic test_mul();
    run_mul("mul", 32'd6, 32'd7, 32'h200, 5'd10);
    tests++;
    if (last.alu !== 32'd42) begin
      fails++;
      $display("FAIL mul_42: got %0d expected 42", bus.alu_out_m);
    end
    // Directly following MUL must take the full latency again.
    run_mul("mul_b2b", 32'hFFFF_FFFE, 32'd3, 32'h204, 5'd11);
  endtask

  task automatic test_mul_stall();
    drive(3'd7, 1'b0, 32'd1000, 32'd1000, 32'h8, 32'h300, 32'h99, 5'd12);
    sb_q.push_back(model(3'd7, 1'b0, 32'd1000, 32'd1000, 32'h8, 32'h300, 32'h99, 5'd12));
    for (int c = 0; c < MUL_LAT - 1; c++) begin
      #1;
      tests++;
      if (bus.alu_busy !== 1'b1) begin
        fails++;
        $display("FAIL mulst_busy[c%0d]: got %b expected 1", c, bus.alu_busy);
      end
      tick();
    end
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (bus.alu_busy !== 1'b0) begin
        fails++;
        $display("FAIL mulst_done_busy[%0d]: got %b expected 0", k, bus.alu_busy);
      end
      tick();
      obs_v = observe();
      tests++;
      if (obs_v !== last) begin
        fails++;
        $display("FAIL mulst_hold[%0d]: got %h expected %h", k, obs_v, last);
      end
    end
    bus.en = 1'b1;
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL mulst_result: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
    #1;
    tests++;
    if (bus.alu_busy !== 1'b1) begin
      fails++;
      $display("FAIL mulst_restart_busy: got %b expected 1", bus.alu_busy);
    end
    // Leave MUL state cleanly: one ADD drains the counter at cnt 0.
    drive(3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h400, 32'h3, 5'd13);
    sb_q.push_back(model(3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h400, 32'h3, 5'd13));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL mulst_after_add: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
  endtask

  task automatic test_flush_stall();
    bus.flush = 1'b1;
    drive(3'd0, 1'b0, 32'd3, 32'd4, 32'd8, 32'h500, 32'h77, 5'd5);
    sb_q.push_back(em_t'(0));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL flush: got %h expected %h", obs_v, exp_v);
    end
    bus.flush = 1'b0;
    drive(3'd2, 1'b0, 32'hF0F0, 32'hFF00, 32'd4, 32'h504, 32'h88, 5'd6);
    sb_q.push_back(model(3'd2, 1'b0, 32'hF0F0, 32'hFF00, 32'd4, 32'h504, 32'h88, 5'd6));
    tick();
    exp_v = sb_q.pop_front();
    obs_v = observe();
    tests++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL after_flush_load: got %h expected %h", obs_v, exp_v);
    end
    last = exp_v;
    bus.en = 1'b0;
    drive(3'd3, 1'b1, 32'h1234, 32'd0, 32'h40, 32'h600, 32'hAA, 5'd20);
    tick();
    obs_v = observe();
    tests++;
    if (obs_v !== last) begin
      fails++;
      $display("FAIL stall_hold: got %h expected %h", obs_v, last);
    end
    bus.flush = 1'b1;
    tick();
    obs_v = observe();
    tests++;
    if (obs_v !== last) begin
      fails++;
      $display("FAIL stall_flush_ignored: got %h expected %h", obs_v, last);
    end
    bus.flush = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    drive(3'd7, 1'b0, 32'd5, 32'd5, 32'h10, 32'h700, 32'd5 ^ 32'd5, 5'd14);
    tick();
    tick();
    reset = 1'b0;
    tick();
    obs_v = observe();
    tests++;
    if (obs_v !== em_t'(0)) begin
      fails++;
      $display("FAIL reset_mid_mul: got %h expected %h", obs_v, em_t'(0));
    end
    #1;
    tests++;
    if (bus.alu_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_mul_busy: got %b expected 1", bus.alu_busy);
    end
    reset = 1'b1;
    last = '0;
    run_mul("mul_after_reset", 32'd5, 32'd5, 32'h700, 5'd14);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.flush = 1'b0;
    drive(3'd0, 1'b0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_add();
    test_sub_branch();
    test_imm();
    test_back_to_back();
    test_mul();
    test_mul_stall();
    test_flush_stall();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
